stage1_inv: RTL

Inverse of the stage-1 encryption transform. Encryption computes `out = (data << key_bits[4:2]) + 3` mod 2^DATA_W; this block computes `out = (cipher - 3) >> key_bits[4:2]` mod 2^DATA_W. It sits on the decrypt path, consuming stage-1 ciphertext, and uses the same ld/start/done handshake as the encrypt stage. The shift is iterative, one bit per cycle, so latency depends on the key. It flags ciphertext that could not have come from the encryptor.

---
 rtl/stage1_pkg.sv | 17 +
 rtl/stage1_inv.sv | 100 ++++++++++
 2 files changed

// File: rtl/stage1_pkg.sv
// Shared definitions for the stage-1 encrypt/decrypt pair.
package stage1_pkg;

   localparam int unsigned DATA_W = 16;
   localparam logic [15:0] STG1_OFFSET = 16'd3;

   // Location of the shift count inside key_bits
   localparam int unsigned KEY_SHIFT_HI = 4;
   localparam int unsigned KEY_SHIFT_LO = 2;
   localparam int unsigned KEY_SHIFT_W  = KEY_SHIFT_HI - KEY_SHIFT_LO + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } stg1_state_e;

endpackage

// File: rtl/stage1_inv.sv
// Stage-1 decrypt: out = (cipher - OFFSET) >> key_bits[4:2], shifted one bit per cycle.
// err reports any 1 shifted out, i.e. ciphertext the encryptor can never produce.
module stage1_inv
   import stage1_pkg::*;
#(
   parameter int unsigned DATA_W = stage1_pkg::DATA_W,
   parameter logic [DATA_W-1:0] OFFSET = DATA_W'(STG1_OFFSET)
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic [4:0]        key_bits,
   input  logic [DATA_W-1:0] cipher_in,
   input  logic              ld,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] stg1_inv_out,
   output logic              err
);

   stg1_state_e            state_q, state_d;
   logic [DATA_W-1:0]      in_reg_q, in_reg_d;
   logic [DATA_W-1:0]      work_q, work_d;
   logic [KEY_SHIFT_W-1:0] cnt_q, cnt_d;
   logic                   err_acc_q, err_acc_d;
   logic [DATA_W-1:0]      out_q, out_d;
   logic                   err_q, err_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;

   // Next-state: IDLE loads/accepts, SHIFT drains one bit per cycle then publishes.
   always_comb begin
      state_d   = state_q;
      in_reg_d  = in_reg_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      err_acc_d = err_acc_q;
      out_d     = out_q;
      err_d     = err_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ld) begin
               // ld wins; a simultaneous start is dropped
               in_reg_d = cipher_in;
            end else if (start) begin
               work_d    = in_reg_q - OFFSET;
               cnt_d     = key_bits[KEY_SHIFT_HI:KEY_SHIFT_LO];
               err_acc_d = 1'b0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               work_d    = work_q >> 1;
               cnt_d     = cnt_q - 1'b1;
               err_acc_d = err_acc_q | work_q[0];
            end else begin
               out_d   = work_q;
               err_d   = err_acc_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         in_reg_q  <= '0;
         work_q    <= '0;
         cnt_q     <= '0;
         err_acc_q <= 1'b0;
         out_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_reg_q  <= in_reg_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         err_acc_q <= err_acc_d;
         out_q     <= out_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign stg1_inv_out = out_q;
   assign err          = err_q;

endmodule
